ifetch: RTL and testbench

Instruction fetch stage for the 16-bit core. It consumes the current PC from the PC register and issues in-order requests to instruction memory. It buffers returned instructions with their PCs for decode, and drives `nextpc` back to the PC register. Branch/jump redirects flush the buffer and discard in-flight responses.

---
 rtl/ifetch.sv | 111 +++++++++++
 tb/tb_ifetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// rtl/ifetch.sv - Instruction fetch stage: in-order imem requests, PC-tagged buffer, redirect discard
module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic [15:0] nextpc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [15:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [15:0] imem_resp_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        if_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]      pc_q    [DEPTH];
  logic [15:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    head_q, tail_q, fill_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    owed;
  logic             fire, deq, resp_drop, resp_fill;

  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, cnt_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign fire           = imem_req_valid && imem_req_ready;

  assign nextpc = redirect_valid ? redirect_pc :
                  fire           ? pc_in + 16'd2 : pc_in;

  assign if_valid = filled_q[head_q] && !redirect_valid;
  assign if_instr = instr_q[head_q];
  assign if_pc    = pc_q[head_q];
  assign deq      = if_valid && if_ready;

  // pend_q counts allocated entries still waiting for data; stale responses are served first
  assign resp_drop = imem_resp_valid && (drop_q != '0);
  assign resp_fill = imem_resp_valid && (drop_q == '0) && (pend_q != '0) && !redirect_valid;
  assign owed      = drop_q + pend_q;

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    if (redirect_valid) begin
      cnt_d    = '0;
      pend_d   = '0;
      filled_d = '0;
      drop_d   = (imem_resp_valid && (owed != '0)) ? owed - CW'(1) : owed;
    end else begin
      cnt_d  = cnt_q + CW'(fire) - CW'(deq);
      pend_d = pend_q + CW'(fire) - CW'(resp_fill);
      drop_d = drop_q - CW'(resp_drop);
      if (resp_fill) filled_d[fill_q] = 1'b1;
      if (deq)       filled_d[head_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
        fill_q <= '0;
      end else begin
        if (fire) begin
          pc_q[tail_q] <= pc_in;
          tail_q       <= tail_q + AW'(1);
        end
        if (resp_fill) begin
          instr_q[fill_q] <= imem_resp_data;
          fill_q          <= fill_q + AW'(1);
        end
        if (deq) head_q <= head_q + AW'(1);
      end
    end
  end

  // A response with nothing outstanding is illegal stimulus
  resp_owed_a: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (drop_q != '0 || pend_q != '0));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - Self-checking bench for ifetch: vector table, directed corners, random vs model
module tb_ifetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in, nextpc, redirect_pc, imem_req_addr, imem_resp_data, if_instr, if_pc;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid, if_valid, if_ready;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .nextpc(nextpc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [15:0] pc; bit arrived; } slot_t;
  typedef struct { bit ifr; bit rdy; bit rv; logic [15:0] np; bit iv; logic [15:0] ipc; } vec_t;

  mreq_t       mq[$];
  slot_t       eq[$];
  vec_t        vt[10];
  int          epoch, cyc, lat, n_chk, n_fail;
  bit          e_fire, e_deq, e_resp;
  logic [15:0] e_np;

  function automatic logic [15:0] memfn(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory drives its response, then the model's view of this cycle is compared
  task automatic eval();
    int stale;
    bit e_rv, e_iv;
    e_resp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = e_resp;
    imem_resp_data  = e_resp ? memfn(mq[0].addr) : 16'h0000;
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    e_rv   = !redirect_valid && ((eq.size() + stale) < DEPTH);
    e_fire = e_rv && imem_req_ready;
    e_np   = redirect_valid ? redirect_pc : (e_fire ? pc_in + 16'd2 : pc_in);
    e_iv   = !redirect_valid && (eq.size() > 0) && eq[0].arrived;
    e_deq  = e_iv && if_ready;
    chk("req_valid", 16'(imem_req_valid), 16'(e_rv));
    chk("req_addr", imem_req_addr, pc_in);
    chk("nextpc", nextpc, e_np);
    chk("if_valid", 16'(if_valid), 16'(e_iv));
    if (e_iv) begin
      chk("if_pc", if_pc, eq[0].pc);
      chk("if_instr", if_instr, memfn(eq[0].pc));
    end
  endtask

  task automatic advance();
    mreq_t m;
    @(posedge clk);
    @(negedge clk);
    if (e_resp) begin
      m = mq.pop_front();
      if (m.epoch == epoch && !redirect_valid) begin
        for (int i = 0; i < eq.size(); i++)
          if (!eq[i].arrived) begin
            eq[i].arrived = 1'b1;
            break;
          end
      end
    end
    if (redirect_valid) begin
      eq.delete();
      epoch++;
    end else begin
      if (e_deq) eq.delete(0);
      if (e_fire) begin
        mq.push_back('{pc_in, cyc + lat, epoch});
        eq.push_back('{pc_in, 1'b0});
      end
    end
    pc_in = e_np;
    cyc++;
  endtask

  task automatic tick();
    eval();
    advance();
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    pc_in           = 16'h0000;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 16'h0000;
    mq.delete();
    eq.delete();
    #1;
    chk("rst_if_valid", 16'(if_valid), 16'h0000);
    chk("rst_req_valid", 16'(imem_req_valid), 16'h0000);
    chk("rst_nextpc", nextpc, pc_in);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_if_instr", if_instr, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_first(logic [15:0] exp, string name);
    bit got = 1'b0;
    logic [15:0] pcv = 16'hxxxx;
    for (int i = 0; i < 30 && !got; i++) begin
      eval();
      if (if_valid) begin
        got = 1'b1;
        pcv = if_pc;
      end
      advance();
    end
    chk({name, "_seen"}, 16'(got), 16'h0001);
    chk(name, pcv, exp);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_req_ready = 1'b1; if_ready = 1'b0; pc_in = 16'h0000;
    imem_resp_valid = 1'b0; imem_resp_data = 16'h0000;

    // DEPTH=2, 1-cycle memory: decode stalled five cycles, then released
    vt[0] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[3] = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[4] = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[5] = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[6] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002};
    vt[7] = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 16'h0000};
    vt[8] = '{1'b1, 1'b1, 1'b0, 16'h0008, 1'b1, 16'h0004};
    vt[9] = '{1'b1, 1'b1, 1'b1, 16'h000A, 1'b1, 16'h0006};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if_ready       = vt[i].ifr;
      imem_req_ready = vt[i].rdy;
      eval();
      chk($sformatf("vec%0d_req_valid", i), 16'(imem_req_valid), 16'(vt[i].rv));
      chk($sformatf("vec%0d_nextpc", i), nextpc, vt[i].np);
      chk($sformatf("vec%0d_if_valid", i), 16'(if_valid), 16'(vt[i].iv));
      if (vt[i].iv) chk($sformatf("vec%0d_if_pc", i), if_pc, vt[i].ipc);
      advance();
    end

    // Redirect with two requests outstanding on a 3-cycle memory
    lat = 3;
    do_reset();
    if_ready = 1'b1; imem_req_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    wait_first(16'h0100, "redir_first_pc");

    // Redirect in the same cycle a response returns
    lat = 2;
    do_reset();
    if_ready = 1'b1; imem_req_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    eval();
    chk("redir_resp_req_valid", 16'(imem_req_valid), 16'h0001);
    advance();
    wait_first(16'h0200, "redir_resp_first_pc");

    // Memory not ready for four cycles at PC 0x0006
    lat = 1;
    do_reset();
    if_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && pc_in != 16'h0006; i++) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("stall_nextpc", nextpc, 16'h0006);
      chk("stall_req_addr", imem_req_addr, 16'h0006);
      advance();
    end
    imem_req_ready = 1'b1;
    eval();
    chk("resume_nextpc", nextpc, 16'h0008);
    advance();

    // Wrap at 0xFFFE, then reset mid-stream
    imem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    eval();
    chk("wrap_req_valid", 16'(imem_req_valid), 16'h0001);
    chk("wrap_nextpc", nextpc, 16'h0000);
    advance();
    tick();
    tick();
    do_reset();
    if_ready = 1'b1;
    eval();
    chk("restart_req_valid", 16'(imem_req_valid), 16'h0001);
    chk("restart_req_addr", imem_req_addr, 16'h0000);
    advance();
    wait_first(16'h0000, "restart_first_pc");

    // Randomized traffic against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        lat            = int'($urandom_range(1, 4));
        if_ready       = ($urandom % 4) != 0;
        imem_req_ready = ($urandom % 4) != 0;
        redirect_valid = ($urandom % 16) == 0;
        redirect_pc    = (($urandom % 8) == 0) ? 16'hFFFC : 16'($urandom) & 16'hFFFE;
        tick();
      end
      redirect_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
